// File: rtl/pool_pe_sched_if.sv
// rtl/pool_pe_sched_if.sv - sample stream, result stream and PE drive bundle for pool_pe_sched
interface pool_pe_sched_if #(
   parameter int DATA_W = 16
);
   // upstream window-ordered samples
   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] in_data;
   // pooled results
   logic                     out_valid;
   logic                     out_ready;
   logic signed [DATA_W-1:0] out_data;
   logic                     out_last;
   // max-pool PE drive and feedback
   logic                     pe_start;
   logic signed [DATA_W-1:0] pe_input;
   logic signed [DATA_W-1:0] pe_last_max;
   logic signed [DATA_W-1:0] pe_output;

   modport master (
      input  in_valid, in_data, out_ready, pe_output,
      output in_ready, out_valid, out_data, out_last, pe_start, pe_input, pe_last_max
   );

   modport slave (
      output in_valid, in_data, out_ready, pe_output,
      input  in_ready, out_valid, out_data, out_last, pe_start, pe_input, pe_last_max
   );
endinterface

// File: rtl/pool_pe_sched.sv
// rtl/pool_pe_sched.sv - sequences one max-pool PE across a pooled feature map
module pool_pe_sched #(
   parameter int DATA_W = 16,
   parameter int POOL_K = 2,
   parameter int OUT_W  = 14,
   parameter int OUT_H  = 14
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cfg_start,
   output logic            busy,
   output logic            done,
   pool_pe_sched_if.master bus
);
   localparam int KK = POOL_K * POOL_K;
   localparam int EW = (KK > 1)    ? $clog2(KK)    : 1;
   localparam int CW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
   localparam int RW = (OUT_H > 1) ? $clog2(OUT_H) : 1;
   localparam logic [EW-1:0] ELEM_LAST = EW'(KK - 1);
   localparam logic [CW-1:0] COL_LAST  = CW'(OUT_W - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(OUT_H - 1);
   // seed for the first element of each window so the previous max never leaks in
   localparam logic signed [DATA_W-1:0] DATA_MIN = {1'b1, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t                   state;
   logic [EW-1:0]            elem_cnt;
   logic [CW-1:0]            col;
   logic [RW-1:0]            row;
   logic                     res_pending;
   logic                     res_last;
   logic                     out_valid_r;
   logic                     out_last_r;
   logic signed [DATA_W-1:0] out_data_r;
   logic                     in_ready_w;
   logic                     accept;
   logic                     out_fire;

   // stall input while a result is pending or the output register is blocked
   assign in_ready_w = (state == S_RUN) && !res_pending && !(out_valid_r && !bus.out_ready);
   assign accept     = bus.in_valid && in_ready_w;
   assign out_fire   = out_valid_r && bus.out_ready;

   assign bus.in_ready  = in_ready_w;
   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = out_data_r;
   assign bus.out_last  = out_last_r;
   assign busy          = (state != S_IDLE);
   assign done          = !reset && (state == S_DRAIN) && out_fire;

   // PE drive: seed/feed on accepts, recirculate the running max on every other cycle
   always_comb begin
      bus.pe_start    = 1'b0;
      bus.pe_input    = '0;
      bus.pe_last_max = '0;
      if (state != S_IDLE) begin
         bus.pe_start = 1'b1;
         if (accept) begin
            bus.pe_input    = bus.in_data;
            bus.pe_last_max = (elem_cnt == '0) ? DATA_MIN : bus.pe_output;
         end else begin
            bus.pe_input    = bus.pe_output;
            bus.pe_last_max = bus.pe_output;
         end
      end
   end

   // frame FSM, window counters and single-entry result register
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         elem_cnt    <= '0;
         col         <= '0;
         row         <= '0;
         res_pending <= 1'b0;
         res_last    <= 1'b0;
         out_valid_r <= 1'b0;
         out_last_r  <= 1'b0;
         out_data_r  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cfg_start) begin
                  state       <= S_RUN;
                  elem_cnt    <= '0;
                  col         <= '0;
                  row         <= '0;
                  res_pending <= 1'b0;
               end
            end
            S_RUN: begin
               if (accept) begin
                  if (elem_cnt == ELEM_LAST) begin
                     elem_cnt    <= '0;
                     res_pending <= 1'b1;
                     res_last    <= (col == COL_LAST) && (row == ROW_LAST);
                     if (col == COL_LAST) begin
                        col <= '0;
                        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                     end else begin
                        col <= col + 1'b1;
                     end
                  end else begin
                     elem_cnt <= elem_cnt + 1'b1;
                  end
               end
               // a load wins over a same-edge drain of the previous result
               if (res_pending) begin
                  out_data_r  <= bus.pe_output;
                  out_valid_r <= 1'b1;
                  out_last_r  <= res_last;
                  res_pending <= 1'b0;
                  if (res_last) begin
                     state <= S_DRAIN;
                  end
               end else if (out_fire) begin
                  out_valid_r <= 1'b0;
                  out_last_r  <= 1'b0;
               end
            end
            S_DRAIN: begin
               if (out_fire) begin
                  out_valid_r <= 1'b0;
                  out_last_r  <= 1'b0;
                  state       <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pool_pe_sched.sv
// tb/tb_pool_pe_sched.sv - self-checking bench for pool_pe_sched with a window-max scoreboard
module tb_pool_pe_sched;
   localparam int DW = 16;

   logic clk = 1'b0;
   logic reset;
   logic cfg_start_a, cfg_start_b, busy_a, busy_b, done_a, done_b;
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;
   bit   rnd = 1'b0;

   // reference model state, index 0 = dut_a, 1 = dut_b
   int exp_d [2][64];
   bit exp_l [2][64];
   int out_hist [2][16];
   int wr [2], rd [2], win_n [2], win_max [2], win_idx [2];
   int done_cnt [2], acc_cnt [2], out_n [2];
   bit done_prev [2];

   pool_pe_sched_if #(.DATA_W(DW)) bus_a ();
   pool_pe_sched_if #(.DATA_W(DW)) bus_b ();

   pool_pe_sched #(.DATA_W(DW), .POOL_K(2), .OUT_W(2), .OUT_H(1)) dut_a (
      .clk(clk), .reset(reset), .cfg_start(cfg_start_a), .busy(busy_a), .done(done_a), .bus(bus_a.master)
   );
   pool_pe_sched #(.DATA_W(DW), .POOL_K(1), .OUT_W(3), .OUT_H(1)) dut_b (
      .clk(clk), .reset(reset), .cfg_start(cfg_start_b), .busy(busy_b), .done(done_b), .bus(bus_b.master)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // behavioural max-pool PEs
   always @(posedge clk) begin
      bus_a.pe_output <= !bus_a.pe_start ? '0 :
         ((bus_a.pe_input > bus_a.pe_last_max) ? bus_a.pe_input : bus_a.pe_last_max);
      bus_b.pe_output <= !bus_b.pe_start ? '0 :
         ((bus_b.pe_input > bus_b.pe_last_max) ? bus_b.pe_input : bus_b.pe_last_max);
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // scoreboard: group accepted samples into windows, max them, match against output handshakes
   task automatic mon(input int s, input string p, input bit rst, input bit ifire, input int idat,
                      input bit ofire, input int odat, input bit olast, input bit dn, input bit bsy,
                      input int kk, input int nw);
      done_cnt[s] += int'(dn);
      if (rst) begin
         wr[s] = 0; rd[s] = 0; win_n[s] = 0; win_idx[s] = 0; done_prev[s] = 1'b0;
         return;
      end
      if (done_prev[s]) chk({p, "_busy_after_done"}, int'(bsy), 0);
      done_prev[s] = dn;
      if (ofire) begin
         if (rd[s] == wr[s]) begin
            chk({p, "_unexpected_result"}, 1, 0);
         end else begin
            chk({p, "_out_data"}, odat, exp_d[s][rd[s] % 64]);
            chk({p, "_out_last"}, int'(olast), int'(exp_l[s][rd[s] % 64]));
            chk({p, "_done_on_last"}, int'(dn), int'(exp_l[s][rd[s] % 64]));
            rd[s]++;
         end
         out_hist[s][out_n[s] % 16] = odat;
         out_n[s]++;
      end else if (dn) begin
         chk({p, "_done_spurious"}, 1, 0);
      end
      if (ifire) begin
         acc_cnt[s]++;
         win_max[s] = (win_n[s] == 0 || idat > win_max[s]) ? idat : win_max[s];
         win_n[s]++;
         if (win_n[s] == kk) begin
            exp_d[s][wr[s] % 64] = win_max[s];
            exp_l[s][wr[s] % 64] = (win_idx[s] == nw - 1);
            win_idx[s] = (win_idx[s] + 1) % nw;
            win_n[s] = 0;
            wr[s]++;
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0, "a", reset, bus_a.in_valid && bus_a.in_ready, int'(bus_a.in_data),
          bus_a.out_valid && bus_a.out_ready, int'(bus_a.out_data), bus_a.out_last, done_a, busy_a, 4, 2);
      mon(1, "b", reset, bus_b.in_valid && bus_b.in_ready, int'(bus_b.in_data),
          bus_b.out_valid && bus_b.out_ready, int'(bus_b.out_data), bus_b.out_last, done_b, busy_b, 1, 3);
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (rnd) begin
         bus_a.out_ready = 1'($urandom_range(0, 1));
         bus_b.out_ready = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic set_in(input int s, input bit v, input int d);
      if (s == 1) begin bus_b.in_valid = v; bus_b.in_data = 16'(d); end
      else        begin bus_a.in_valid = v; bus_a.in_data = 16'(d); end
   endtask

   task automatic set_ordy(input int s, input bit v);
      if (s == 1) bus_b.out_ready = v;
      else        bus_a.out_ready = v;
   endtask

   task automatic start(input int s);
      if (s == 1) cfg_start_b = 1'b1; else cfg_start_a = 1'b1;
      step();
      cfg_start_a = 1'b0;
      cfg_start_b = 1'b0;
   endtask

   task automatic send(input int s, input int v);
      set_in(s, 1'b1, v);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if ((s == 1) ? bus_b.in_ready : bus_a.in_ready) begin
            step();
            set_in(s, 1'b0, 0);
            return;
         end
         step();
      end
      chk("send_timeout", 0, 1);
      set_in(s, 1'b0, 0);
   endtask

   task automatic wait_idle(input int s);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!((s == 1) ? busy_b : busy_a)) begin
            step();
            return;
         end
         step();
      end
      chk("idle_timeout", 0, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int d0, n0, a0, t0, t1, t2;
      int basic [8] = '{3, -5, 7, 1, -8, -2, -9, -4};
      reset = 1'b1;
      cfg_start_a = 1'b0; cfg_start_b = 1'b0;
      bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.out_ready = 1'b0;
      bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.out_ready = 1'b0;
      step(); step();
      reset = 1'b0;

      // reset state
      chk("rst_busy", int'(busy_a), 0);
      chk("rst_done", int'(done_a), 0);
      chk("rst_in_ready", int'(bus_a.in_ready), 0);
      chk("rst_out_valid", int'(bus_a.out_valid), 0);
      chk("rst_out_last", int'(bus_a.out_last), 0);
      chk("rst_out_data", int'(bus_a.out_data), 0);
      chk("rst_pe_start", int'(bus_a.pe_start), 0);
      chk("rst_pe_input", int'(bus_a.pe_input), 0);
      chk("rst_pe_last_max", int'(bus_a.pe_last_max), 0);
      chk("rst_b_busy", int'(busy_b), 0);

      // basic frame with an ignored mid-frame cfg_start
      set_ordy(0, 1'b1);
      d0 = done_cnt[0]; n0 = out_n[0];
      start(0);
      chk("a_busy_run", int'(busy_a), 1);
      for (int i = 0; i < 8; i++) begin
         send(0, basic[i]);
         if (i == 2) start(0);
      end
      wait_idle(0);
      chk("a_basic_done", done_cnt[0] - d0, 1);
      chk("a_basic_res0", out_hist[0][n0 % 16], 7);
      chk("a_basic_res1", out_hist[0][(n0 + 1) % 16], -2);

      // all-negative window after a window with max 7
      n0 = out_n[0];
      start(0);
      send(0, 3); send(0, -5); send(0, 7); send(0, 1);
      for (int i = 0; i < 4; i++) send(0, -32768);
      wait_idle(0);
      chk("a_neg_res0", out_hist[0][n0 % 16], 7);
      chk("a_neg_res1", out_hist[0][(n0 + 1) % 16], -32768);

      // input stall inside a window
      n0 = out_n[0];
      start(0);
      send(0, 5); send(0, 9);
      for (int i = 0; i < 3; i++) begin
         chk("a_stall_pe_start", int'(bus_a.pe_start), 1);
         chk("a_stall_pe_input", int'(bus_a.pe_input), 9);
         chk("a_stall_pe_last_max", int'(bus_a.pe_last_max), 9);
         chk("a_stall_pe_output", int'(bus_a.pe_output), 9);
         step();
      end
      send(0, 2); send(0, 4);
      for (int i = 0; i < 4; i++) send(0, 0);
      wait_idle(0);
      chk("a_stall_res", out_hist[0][n0 % 16], 9);

      // output back-pressure
      n0 = out_n[0];
      set_ordy(0, 1'b0);
      start(0);
      send(0, 3); send(0, -5); send(0, 7); send(0, 1);
      set_in(0, 1'b1, -8);
      a0 = acc_cnt[0];
      for (int i = 0; i < 6; i++) begin
         step();
         chk("a_bp_out_valid", int'(bus_a.out_valid), 1);
         chk("a_bp_out_data", int'(bus_a.out_data), 7);
         chk("a_bp_in_ready", int'(bus_a.in_ready), 0);
      end
      chk("a_bp_no_accept", acc_cnt[0] - a0, 0);
      set_ordy(0, 1'b1);
      send(0, -8); send(0, -2); send(0, -9); send(0, -4);
      wait_idle(0);
      chk("a_bp_res1", out_hist[0][(n0 + 1) % 16], -2);

      // reset mid-frame, then a clean frame
      start(0);
      send(0, 3); send(0, -5);
      d0 = done_cnt[0];
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("a_mrst_busy", int'(busy_a), 0);
      chk("a_mrst_in_ready", int'(bus_a.in_ready), 0);
      chk("a_mrst_out_valid", int'(bus_a.out_valid), 0);
      chk("a_mrst_pe_start", int'(bus_a.pe_start), 0);
      step();
      chk("a_mrst_no_done", done_cnt[0] - d0, 0);
      n0 = out_n[0];
      start(0);
      send(0, 5); send(0, 9); send(0, 2); send(0, 4);
      for (int i = 0; i < 4; i++) send(0, -1);
      wait_idle(0);
      chk("a_mrst_done", done_cnt[0] - d0, 1);
      chk("a_mrst_res0", out_hist[0][n0 % 16], 9);
      chk("a_mrst_res1", out_hist[0][(n0 + 1) % 16], -1);

      // POOL_K=1: in_valid ignored while idle, then 4,-1,0 with one bubble per accept
      a0 = acc_cnt[1];
      set_in(1, 1'b1, 55);
      step(); step();
      chk("b_idle_in_ready", int'(bus_b.in_ready), 0);
      set_in(1, 1'b0, 0);
      chk("b_idle_no_accept", acc_cnt[1] - a0, 0);
      set_ordy(1, 1'b1);
      n0 = out_n[1]; d0 = done_cnt[1];
      start(1);
      send(1, 4);  t0 = cyc;
      send(1, -1); t1 = cyc;
      send(1, 0);  t2 = cyc;
      wait_idle(1);
      chk("b_gap01", t1 - t0, 2);
      chk("b_gap12", t2 - t1, 2);
      chk("b_res0", out_hist[1][n0 % 16], 4);
      chk("b_res1", out_hist[1][(n0 + 1) % 16], -1);
      chk("b_res2", out_hist[1][(n0 + 2) % 16], 0);
      chk("b_done", done_cnt[1] - d0, 1);

      // randomized frames with random gaps and back-pressure on both instances
      rnd = 1'b1;
      for (int s = 0; s < 2; s++) begin
         d0 = done_cnt[s];
         for (int f = 0; f < 12; f++) begin
            start(s);
            for (int i = 0; i < ((s == 0) ? 8 : 3); i++) begin
               repeat ($urandom_range(0, 2)) step();
               if ($urandom_range(0, 7) == 0) send(s, -32768);
               else send(s, int'($urandom_range(0, 65535)) - 32768);
            end
            wait_idle(s);
         end
         chk((s == 0) ? "a_rand_done" : "b_rand_done", done_cnt[s] - d0, 12);
         chk((s == 0) ? "a_rand_drained" : "b_rand_drained", wr[s] - rd[s], 0);
      end
      rnd = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
